option_selector: RTL and testbench

- Parametrised keyboard-driven option selector: replaces the fixed 4-way tank chooser in the menu/select screen.
- Steps through NUM_OPTIONS choices with PREV/NEXT keys (wrap-around, edge-detected, hold-to-auto-repeat).
- Locks the choice with CONFIRM and releases it with CANCEL.
- Active only while the game FSM is in SELECT_STATE; downstream sprite/game logic reads selection, locked and the pulses.

---
 rtl/option_selector_if.sv | 21 ++
 rtl/option_selector.sv | 119 +++++++++++
 tb/tb_option_selector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/option_selector_if.sv
// Bundles the keyboard/state inputs and the selection outputs of option_selector.
interface option_selector_if #(
    parameter int unsigned SEL_W = 2
);
    logic [7:0]       keycode;
    logic [1:0]       currentState;
    logic [SEL_W-1:0] selection;
    logic             locked;
    logic             changed_pulse;
    logic             confirm_pulse;

    modport master (
        output keycode, currentState,
        input  selection, locked, changed_pulse, confirm_pulse
    );

    modport slave (
        input  keycode, currentState,
        output selection, locked, changed_pulse, confirm_pulse
    );
endinterface

// File: rtl/option_selector.sv
// Keyboard-driven option selector: PREV/NEXT stepping with wrap and auto-repeat,
// CONFIRM/CANCEL locking, active only in the select state of the game FSM.
module option_selector #(
    parameter int unsigned NUM_OPTIONS  = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned RESET_INDEX  = 0,
    parameter logic [7:0]  KEY_PREV     = 8'h14,
    parameter logic [7:0]  KEY_NEXT     = 8'h08,
    parameter logic [7:0]  KEY_CONFIRM  = 8'h28,
    parameter logic [7:0]  KEY_CANCEL   = 8'h29,
    parameter logic [1:0]  SELECT_STATE = 2'd0,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 6250000
) (
    input logic              Clk,
    input logic              Reset,
    option_selector_if.slave bus
);
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_OPTIONS - 1);
    localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_INDEX);
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DELAY, RATE} rptState_t;

    rptState_t        rptState, rptNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [7:0]       keyQ;
    logic [SEL_W-1:0] selection, selNext;
    logic             locked, lockNext;
    logic             changedPulse, confirmPulse, confirmNext;
    logic             active, press, isStepKey, evalPress, doStep, stepUp;

    assign active    = (bus.currentState == SELECT_STATE);
    assign press     = (bus.keycode != 8'h00) && (bus.keycode != keyQ);
    assign isStepKey = (bus.keycode == KEY_NEXT) || (bus.keycode == KEY_PREV);

    always_comb begin
        rptNext     = rptState;
        cntNext     = cnt;
        lockNext    = locked;
        confirmNext = 1'b0;
        doStep      = 1'b0;
        stepUp      = (bus.keycode == KEY_NEXT);
        evalPress   = 1'b0;
        if (!active) begin
            rptNext = IDLE;
            cntNext = '0;
        end else begin
            // A key change ends the repeat and is then judged as a fresh press from IDLE.
            case (rptState)
                DELAY, RATE: begin
                    if (bus.keycode != keyQ) begin
                        rptNext   = IDLE;
                        cntNext   = '0;
                        evalPress = 1'b1;
                    end else if (cnt == ((rptState == DELAY) ? DELAY_END : RATE_END)) begin
                        doStep  = 1'b1;
                        cntNext = CNT_ONE;
                        rptNext = RATE;
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
                default: evalPress = 1'b1;
            endcase
            if (evalPress && press) begin
                if (!locked && isStepKey) begin
                    doStep  = 1'b1;
                    cntNext = CNT_ONE;
                    rptNext = DELAY;
                end else if (!locked && bus.keycode == KEY_CONFIRM) begin
                    lockNext    = 1'b1;
                    confirmNext = 1'b1;
                    rptNext     = IDLE;
                end else if (locked && bus.keycode == KEY_CANCEL) begin
                    lockNext = 1'b0;
                end
            end
        end
    end

    always_comb begin
        selNext = selection;
        if (doStep) begin
            if (stepUp) selNext = (selection == LAST_SEL) ? '0 : selection + SEL_W'(1);
            else        selNext = (selection == '0) ? LAST_SEL : selection - SEL_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            keyQ         <= 8'h00;
            rptState     <= IDLE;
            cnt          <= '0;
            selection    <= RESET_SEL;
            locked       <= 1'b0;
            changedPulse <= 1'b0;
            confirmPulse <= 1'b0;
        end else begin
            keyQ         <= bus.keycode;
            rptState     <= rptNext;
            cnt          <= cntNext;
            selection    <= selNext;
            locked       <= lockNext;
            changedPulse <= doStep;
            confirmPulse <= confirmNext;
        end
    end

    assign bus.selection     = selection;
    assign bus.locked        = locked;
    assign bus.changed_pulse = changedPulse;
    assign bus.confirm_pulse = confirmPulse;
endmodule

// File: tb/tb_option_selector.sv
// Directed bench for option_selector: a 4-option instance with short repeat
// timing and a 5-option instance for non-power-of-two wrap behaviour.
module tb_option_selector;
    localparam logic [7:0] NXT = 8'h08;
    localparam logic [7:0] PRV = 8'h14;
    localparam logic [7:0] CNF = 8'h28;
    localparam logic [7:0] CNL = 8'h29;
    localparam logic [7:0] OTH = 8'h55;

    logic Clk;
    logic Reset;
    int   cmpCnt = 0;
    int   errCnt = 0;

    option_selector_if #(.SEL_W(2)) ifA ();
    option_selector_if #(.SEL_W(3)) ifB ();

    option_selector #(
        .NUM_OPTIONS(4), .SEL_W(2), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dutA (
        .Clk(Clk), .Reset(Reset), .bus(ifA)
    );

    option_selector #(
        .NUM_OPTIONS(5), .SEL_W(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dutB (
        .Clk(Clk), .Reset(Reset), .bus(ifB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string tag;
        bit    useB;
        int    sel;
        bit    lk;
        bit    chg;
        bit    cf;
    } exp_t;

    exp_t sb[$];

    task automatic expectOut(input bit useB, input int sel, input bit lk, input bit chg,
                             input bit cf, input string tag);
        exp_t e;
        e.tag = tag; e.useB = useB; e.sel = sel; e.lk = lk; e.chg = chg; e.cf = cf;
        sb.push_back(e);
    endtask

    task automatic checkOut();
        exp_t        e;
        logic [31:0] oSel;
        logic        oLk, oChg, oCf;
        e = sb.pop_front();
        if (e.useB) begin
            oSel = 32'(ifB.selection); oLk = ifB.locked; oChg = ifB.changed_pulse; oCf = ifB.confirm_pulse;
        end else begin
            oSel = 32'(ifA.selection); oLk = ifA.locked; oChg = ifA.changed_pulse; oCf = ifA.confirm_pulse;
        end
        cmpCnt++;
        assert (oSel === 32'(e.sel)) else begin
            errCnt++;
            $error("FAIL %s selection: got %0d expected %0d", e.tag, oSel, e.sel);
        end
        cmpCnt++;
        assert (oLk === e.lk) else begin
            errCnt++;
            $error("FAIL %s locked: got %b expected %b", e.tag, oLk, e.lk);
        end
        cmpCnt++;
        assert (oChg === e.chg) else begin
            errCnt++;
            $error("FAIL %s changed_pulse: got %b expected %b", e.tag, oChg, e.chg);
        end
        cmpCnt++;
        assert (oCf === e.cf) else begin
            errCnt++;
            $error("FAIL %s confirm_pulse: got %b expected %b", e.tag, oCf, e.cf);
        end
    endtask

    // Drive one cycle of input at the falling edge, check the result one edge later.
    task automatic tick(input bit useB, input logic [7:0] k, input logic [1:0] st, input int sel,
                        input bit lk, input bit chg, input bit cf, input string tag);
        if (useB) begin
            ifB.keycode = k; ifB.currentState = st;
        end else begin
            ifA.keycode = k; ifA.currentState = st;
        end
        expectOut(useB, sel, lk, chg, cf, tag);
        @(posedge Clk);
        @(negedge Clk);
        checkOut();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int          expSel;
        bit          st;
        logic [7:0]  keys [6];
        logic [7:0]  k;
        keys = '{8'h00, NXT, PRV, CNF, CNL, OTH};

        Reset = 1'b1;
        ifA.keycode = 8'h00; ifA.currentState = 2'd0;
        ifB.keycode = 8'h00; ifB.currentState = 2'd0;
        repeat (2) @(negedge Clk);
        expectOut(0, 0, 0, 0, 0, "resetA"); checkOut();
        expectOut(1, 0, 0, 0, 0, "resetB"); checkOut();
        Reset = 1'b0;

        // single presses with wrap
        for (int i = 0; i < 5; i++) begin
            tick(0, NXT, 2'd0, (i + 1) % 4, 0, 1, 0, "nextStep");
            tick(0, 8'h00, 2'd0, (i + 1) % 4, 0, 0, 0, "nextRel");
        end
        tick(0, PRV, 2'd0, 0, 0, 1, 0, "prevStep");
        tick(0, 8'h00, 2'd0, 0, 0, 0, 0, "prevRel");
        tick(0, PRV, 2'd0, 3, 0, 1, 0, "prevWrap");
        tick(0, 8'h00, 2'd0, 3, 0, 0, 0, "prevRel");
        tick(0, NXT, 2'd0, 0, 0, 1, 0, "nextWrap");
        tick(0, 8'h00, 2'd0, 0, 0, 0, 0, "nextRel");

        // auto-repeat: steps at edges 0, 4, 6, 8
        expSel = 0;
        for (int e = 0; e < 10; e++) begin
            st = (e == 0) || (e == 4) || (e == 6) || (e == 8);
            if (st) expSel = (expSel + 1) % 4;
            tick(0, NXT, 2'd0, expSel, 0, st, 0, "repeat");
        end
        for (int e = 0; e < 3; e++) tick(0, 8'h00, 2'd0, 0, 0, 0, 0, "repeatRel");

        // locking
        tick(0, CNF, 2'd0, 0, 1, 0, 1, "confirm");
        tick(0, 8'h00, 2'd0, 0, 1, 0, 0, "confirmRel");
        tick(0, NXT, 2'd0, 0, 1, 0, 0, "lockedNext");
        for (int e = 0; e < 6; e++) tick(0, NXT, 2'd0, 0, 1, 0, 0, "lockedHold");
        tick(0, 8'h00, 2'd0, 0, 1, 0, 0, "lockedRel");
        tick(0, CNF, 2'd0, 0, 1, 0, 0, "confirmAgain");
        tick(0, 8'h00, 2'd0, 0, 1, 0, 0, "confirmRel");
        tick(0, CNL, 2'd0, 0, 0, 0, 0, "cancel");
        tick(0, 8'h00, 2'd0, 0, 0, 0, 0, "cancelRel");
        tick(0, NXT, 2'd0, 1, 0, 1, 0, "unlockedNext");
        tick(0, 8'h00, 2'd0, 1, 0, 0, 0, "nextRel");

        // activity gating
        tick(0, NXT, 2'd1, 1, 0, 0, 0, "inactivePress");
        tick(0, NXT, 2'd1, 1, 0, 0, 0, "inactiveHold");
        for (int e = 0; e < 6; e++) tick(0, NXT, 2'd0, 1, 0, 0, 0, "heldIntoSelect");
        tick(0, 8'h00, 2'd1, 1, 0, 0, 0, "inactiveRel");
        tick(0, PRV, 2'd1, 1, 0, 0, 0, "inactivePrev");
        tick(0, 8'h00, 2'd0, 1, 0, 0, 0, "activeIdle");
        tick(0, CNF, 2'd0, 1, 1, 0, 1, "lock2");
        tick(0, 8'h00, 2'd1, 1, 1, 0, 0, "lockKept");
        tick(0, CNL, 2'd1, 1, 1, 0, 0, "cancelInactive");
        tick(0, 8'h00, 2'd0, 1, 1, 0, 0, "lockKept2");
        tick(0, CNL, 2'd0, 1, 0, 0, 0, "cancel2");
        tick(0, 8'h00, 2'd0, 1, 0, 0, 0, "cancelRel2");

        // key change while repeating
        tick(0, NXT, 2'd0, 2, 0, 1, 0, "holdNext");
        tick(0, NXT, 2'd0, 2, 0, 0, 0, "holdNext");
        tick(0, PRV, 2'd0, 1, 0, 1, 0, "switchToPrev");
        for (int e = 0; e < 3; e++) tick(0, PRV, 2'd0, 1, 0, 0, 0, "prevHold");
        tick(0, 8'h00, 2'd0, 1, 0, 0, 0, "prevRel");
        tick(0, NXT, 2'd0, 2, 0, 1, 0, "holdNext2");
        tick(0, NXT, 2'd0, 2, 0, 0, 0, "holdNext2");
        for (int e = 0; e < 6; e++) tick(0, OTH, 2'd0, 2, 0, 0, 0, "otherKey");
        tick(0, 8'h00, 2'd0, 2, 0, 0, 0, "otherRel");

        // asynchronous reset between edges, key held through deassertion
        tick(0, CNF, 2'd0, 2, 1, 0, 1, "lock3");
        tick(0, 8'h00, 2'd0, 2, 1, 0, 0, "lock3Rel");
        #2 Reset = 1'b1;
        ifA.keycode = NXT;
        #1;
        expectOut(0, 0, 0, 0, 0, "asyncResetA"); checkOut();
        @(negedge Clk);
        Reset = 1'b0;
        tick(0, NXT, 2'd0, 1, 0, 1, 0, "heldThroughReset");
        tick(0, NXT, 2'd0, 1, 0, 0, 0, "heldAfterReset");
        tick(0, 8'h00, 2'd0, 1, 0, 0, 0, "heldRel");

        // five-option instance
        for (int i = 0; i < 5; i++) begin
            tick(1, NXT, 2'd0, (i + 1) % 5, 0, 1, 0, "bNext");
            tick(1, 8'h00, 2'd0, (i + 1) % 5, 0, 0, 0, "bNextRel");
        end
        tick(1, PRV, 2'd0, 4, 0, 1, 0, "bPrevWrap");
        tick(1, 8'h00, 2'd0, 4, 0, 0, 0, "bPrevRel");
        tick(1, NXT, 2'd0, 0, 0, 1, 0, "bNextWrap");
        tick(1, 8'h00, 2'd0, 0, 0, 0, 0, "bNextRel");

        for (int c = 0; c < 300; c++) begin
            k = keys[$urandom_range(5)];
            ifB.keycode = k;
            ifB.currentState = 2'($urandom_range(1));
            @(posedge Clk);
            @(negedge Clk);
            cmpCnt++;
            assert (ifB.selection < 3'd5) else begin
                errCnt++;
                $error("FAIL bRange: got selection %0d required below 5", ifB.selection);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end
endmodule
